// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: button conditioning plus run/pause/lap control for the
// seconds stopwatch; emits the 1 s tick, counter clear and lap display hold.

`timescale 1ns/1ps

module stopwatch_btn #(
    parameter int DEB_CYCLES = 200000,
    parameter int DEB_W      = 18
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_btn_n,
    output logic o_press
);

    localparam logic [DEB_W-1:0] L_LAST = DEB_W'(DEB_CYCLES - 1);

    logic             r_meta;
    logic             r_sync;
    logic             r_deb;
    logic             r_press;
    logic [DEB_W-1:0] r_cnt;
    logic             w_diff;
    logic             w_take;

    assign w_diff = r_sync ^ r_deb;
    assign w_take = w_diff && (r_cnt == L_LAST);

    // synchronise, debounce, and pulse on the released->pressed change
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta  <= 1'b1;
            r_sync  <= 1'b1;
            r_deb   <= 1'b1;
            r_cnt   <= '0;
            r_press <= 1'b0;
        end else begin
            r_meta  <= i_btn_n;
            r_sync  <= r_meta;
            r_press <= w_take && r_deb;
            if (!w_diff) begin
                r_cnt <= '0;
            end else if (w_take) begin
                r_deb <= r_sync;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_press = r_press;

endmodule

module stopwatch_ctrl #(
    parameter int TICK_DIV   = 10000000,
    parameter int DIV_W      = 24,
    parameter int DEB_CYCLES = 200000,
    parameter int DEB_W      = 18
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_start_stop,
    input  logic       btn_lap,
    output logic       count_enable,
    output logic       cnt_clear,
    output logic       display_hold,
    output logic       running,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_LAP   = 2'd3
    } state_t;

    localparam logic [DIV_W-1:0] L_RELOAD = DIV_W'(TICK_DIV - 1);

    state_t           r_state;
    logic [DIV_W-1:0] r_pre;
    logic             r_ce;
    logic             r_clr;
    logic             r_hold;
    logic             r_run;

    state_t           w_state_nxt;
    logic [DIV_W-1:0] w_pre_nxt;
    logic             w_ce_nxt;
    logic             w_clr_nxt;
    logic             w_hold_nxt;
    logic             w_run_nxt;
    logic             w_active;
    logic             w_ev_ss;
    logic             w_ev_lap;

    stopwatch_btn #(
        .DEB_CYCLES (DEB_CYCLES),
        .DEB_W      (DEB_W)
    ) u_btn_ss (
        .clk     (clk),
        .rst_n   (reset),
        .i_btn_n (btn_start_stop),
        .o_press (w_ev_ss)
    );

    stopwatch_btn #(
        .DEB_CYCLES (DEB_CYCLES),
        .DEB_W      (DEB_W)
    ) u_btn_lap (
        .clk     (clk),
        .rst_n   (reset),
        .i_btn_n (btn_lap),
        .o_press (w_ev_lap)
    );

    assign w_active = (r_state == S_RUN) || (r_state == S_LAP);

    // next state, lap hold and clear; start/stop beats a same-cycle lap
    always_comb begin
        w_state_nxt = r_state;
        w_hold_nxt  = r_hold;
        w_clr_nxt   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_ev_ss) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (w_ev_ss) begin
                    w_state_nxt = S_PAUSE;
                end else if (w_ev_lap) begin
                    w_state_nxt = S_LAP;
                    w_hold_nxt  = 1'b1;
                end
            end
            S_LAP: begin
                if (w_ev_ss) begin
                    w_state_nxt = S_PAUSE;
                end else if (w_ev_lap) begin
                    w_state_nxt = S_RUN;
                    w_hold_nxt  = 1'b0;
                end
            end
            S_PAUSE: begin
                if (w_ev_ss) begin
                    w_state_nxt = r_hold ? S_LAP : S_RUN;
                end else if (w_ev_lap) begin
                    w_state_nxt = S_IDLE;
                    w_hold_nxt  = 1'b0;
                    w_clr_nxt   = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // prescaler runs off the current state; phase is kept while stopped
    always_comb begin
        w_pre_nxt = r_pre;
        w_ce_nxt  = 1'b0;
        if (w_active) begin
            if (r_pre == '0) begin
                w_pre_nxt = L_RELOAD;
                w_ce_nxt  = 1'b1;
            end else begin
                w_pre_nxt = r_pre - 1'b1;
            end
        end else if (w_clr_nxt) begin
            w_pre_nxt = L_RELOAD;
        end
        w_run_nxt = (w_state_nxt == S_RUN) || (w_state_nxt == S_LAP);
    end

    // register state, prescaler and all outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_pre   <= L_RELOAD;
            r_ce    <= 1'b0;
            r_clr   <= 1'b0;
            r_hold  <= 1'b0;
            r_run   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_pre   <= w_pre_nxt;
            r_ce    <= w_ce_nxt;
            r_clr   <= w_clr_nxt;
            r_hold  <= w_hold_nxt;
            r_run   <= w_run_nxt;
        end
    end

    assign count_enable = r_ce;
    assign cnt_clear    = r_clr;
    assign display_hold = r_hold;
    assign running      = r_run;
    assign state        = r_state;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: directed and random checks of stopwatch_ctrl
// against a sample-history / run-count reference model.

`timescale 1ns/1ps

module tb_stopwatch_ctrl;

    localparam int TD  = 10;
    localparam int DEB = 4;

    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic       bss   = 1'b1;
    logic       blap  = 1'b1;
    logic       count_enable;
    logic       cnt_clear;
    logic       display_hold;
    logic       running;
    logic [1:0] state;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    stopwatch_ctrl #(
        .TICK_DIV   (TD),
        .DIV_W      (4),
        .DEB_CYCLES (DEB),
        .DEB_W      (3)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .btn_start_stop (bss),
        .btn_lap        (blap),
        .count_enable   (count_enable),
        .cnt_clear      (cnt_clear),
        .display_hold   (display_hold),
        .running        (running),
        .state          (state)
    );

    // reference model
    logic [1:0] m_state;
    bit         m_hold, m_ce, m_clr;
    bit         m_pss, m_plap, m_dss, m_dlap;
    int         m_run;
    bit         q_ss[$];
    bit         q_lap[$];

    task automatic model_reset();
        m_state = 2'd0;
        m_hold  = 0;
        m_ce    = 0;
        m_clr   = 0;
        m_pss   = 0;
        m_plap  = 0;
        m_dss   = 1;
        m_dlap  = 1;
        m_run   = 0;
        q_ss.delete();
        q_lap.delete();
        repeat (DEB + 2) begin
            q_ss.push_back(1'b1);
            q_lap.push_back(1'b1);
        end
    endtask

    // level accepted when the DEB synced samples before this edge all differ
    function automatic bit fires(input bit sel, input bit deb);
        int sz;
        bit f;
        sz = sel ? q_lap.size() : q_ss.size();
        f  = 1'b1;
        for (int i = 1; i <= DEB; i++) begin
            if ((sel ? q_lap[sz-1-i] : q_ss[sz-1-i]) == deb) f = 1'b0;
        end
        return f;
    endfunction

    task automatic model_edge(input bit ss, input bit lap);
        bit ev_ss, ev_lap, f;
        ev_ss  = m_pss;
        ev_lap = m_plap;
        if (m_state == 2'd1 || m_state == 2'd3) begin
            m_run++;
            m_ce = (m_run % TD) == 0;
        end else begin
            m_ce = 0;
        end
        m_clr = 0;
        if (ev_ss) begin
            case (m_state)
                2'd0:    m_state = 2'd1;
                2'd1:    m_state = 2'd2;
                2'd3:    m_state = 2'd2;
                default: m_state = m_hold ? 2'd3 : 2'd1;
            endcase
        end else if (ev_lap) begin
            case (m_state)
                2'd1: begin m_state = 2'd3; m_hold = 1; end
                2'd3: begin m_state = 2'd1; m_hold = 0; end
                2'd2: begin m_state = 2'd0; m_hold = 0; m_clr = 1; m_run = 0; end
                default: ;
            endcase
        end
        f = fires(1'b0, m_dss);
        m_pss = f && m_dss;
        if (f) m_dss = !m_dss;
        f = fires(1'b1, m_dlap);
        m_plap = f && m_dlap;
        if (f) m_dlap = !m_dlap;
        q_ss.push_back(ss);
        q_lap.push_back(lap);
        if (q_ss.size() > DEB + 4) void'(q_ss.pop_front());
        if (q_lap.size() > DEB + 4) void'(q_lap.pop_front());
    endtask

    function automatic logic [5:0] exp_vec();
        return {m_state, (m_state == 2'd1 || m_state == 2'd3), m_ce, m_clr, m_hold};
    endfunction

    function automatic logic [5:0] obs();
        return {state, running, count_enable, cnt_clear, display_hold};
    endfunction

    // drive at a falling edge, advance one rising edge, settle to next fall
    task automatic cyc(input bit ss, input bit lap);
        bss  = ss;
        blap = lap;
        @(posedge clk);
        model_edge(ss, lap);
        #1;
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        bss   = 1'b1;
        blap  = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        bss   = 1'b0;
        blap  = 1'b0;
        reset = 1'b0;
        model_reset();
        #1;
        n_chk++;
        if (obs() !== 6'd0) begin
            n_fail++;
            $display("FAIL reset_outs: got %b want %b", obs(), 6'd0);
        end
        n_chk++;
        if (dut.r_pre !== 4'(TD - 1)) begin
            n_fail++;
            $display("FAIL reset_pre: got %0d want %0d", dut.r_pre, TD - 1);
        end
        @(negedge clk);
        bss   = 1'b1;
        blap  = 1'b1;
        reset = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, 1'b1);
            n_chk++;
            if (obs() !== exp_vec()) begin
                n_fail++;
                $display("FAIL reset_idle: got %b want %b", obs(), exp_vec());
            end
        end
    endtask

    task automatic test_start();
        int np;
        do_reset();
        for (int i = 1; i <= 60; i++) begin
            cyc(i <= 8 ? 1'b0 : 1'b1, 1'b1);
            n_chk++;
            if (obs() !== exp_vec()) begin
                n_fail++;
                $display("FAIL start_seq cyc %0d: got %b want %b", i, obs(), exp_vec());
            end
            if (i == 6) begin
                n_chk++;
                if (state !== 2'd0) begin
                    n_fail++;
                    $display("FAIL start_early cyc 6: state %0d want 0", state);
                end
            end
            if (i == 7) begin
                n_chk++;
                if (state !== 2'd1 || running !== 1'b1) begin
                    n_fail++;
                    $display("FAIL start_enter: state %0d run %b want 1 1", state, running);
                end
            end
            if (i == 17) begin
                n_chk++;
                if (count_enable !== 1'b1) begin
                    n_fail++;
                    $display("FAIL start_first_tick: got %b want 1", count_enable);
                end
            end
        end
        np = 0;
        for (int i = 0; i < 50; i++) begin
            cyc(1'b1, 1'b1);
            n_chk++;
            if (obs() !== exp_vec()) begin
                n_fail++;
                $display("FAIL start_run cyc %0d: got %b want %b", i, obs(), exp_vec());
            end
            if (count_enable === 1'b1) np++;
        end
        n_chk++;
        if (np !== 5) begin
            n_fail++;
            $display("FAIL start_pulse_count: got %0d want 5", np);
        end
    endtask

    task automatic test_bounce();
        do_reset();
        for (int i = 0; i < 28; i++) begin
            cyc((i < 16 && (i % 4) != 3) ? 1'b0 : 1'b1, 1'b1);
            n_chk++;
            if (obs() !== exp_vec()) begin
                n_fail++;
                $display("FAIL bounce_seq cyc %0d: got %b want %b", i, obs(), exp_vec());
            end
            n_chk++;
            if (state !== 2'd0 || count_enable !== 1'b0) begin
                n_fail++;
                $display("FAIL bounce_ignored cyc %0d: state %0d ce %b want 0 0", i, state, count_enable);
            end
        end
    endtask

    task automatic test_lap();
        int last, idx;
        do_reset();
        last = -1;
        idx  = 0;
        for (int i = 0; i < 74; i++) begin
            if (i < 20) cyc(i < 8 ? 1'b0 : 1'b1, 1'b1);
            else        cyc(1'b1, (i >= 30 && i < 36) ? 1'b0 : 1'b1);
            idx++;
            n_chk++;
            if (obs() !== exp_vec()) begin
                n_fail++;
                $display("FAIL lap_seq cyc %0d: got %b want %b", i, obs(), exp_vec());
            end
            if (count_enable === 1'b1) begin
                if (last >= 0) begin
                    n_chk++;
                    if (idx - last !== TD) begin
                        n_fail++;
                        $display("FAIL lap_spacing: got %0d want %0d", idx - last, TD);
                    end
                end
                last = idx;
            end
        end
        n_chk++;
        if (state !== 2'd3 || display_hold !== 1'b1) begin
            n_fail++;
            $display("FAIL lap_enter: state %0d hold %b want 3 1", state, display_hold);
        end
        for (int i = 0; i < 14; i++) begin
            cyc(i < 6 ? 1'b0 : 1'b1, 1'b1);
            n_chk++;
            if (obs() !== exp_vec()) begin
                n_fail++;
                $display("FAIL lap_pause cyc %0d: got %b want %b", i, obs(), exp_vec());
            end
        end
        n_chk++;
        if (state !== 2'd2 || display_hold !== 1'b1) begin
            n_fail++;
            $display("FAIL lap_to_pause: state %0d hold %b want 2 1", state, display_hold);
        end
        for (int i = 0; i < 14; i++) begin
            cyc(i < 6 ? 1'b0 : 1'b1, 1'b1);
            n_chk++;
            if (obs() !== exp_vec()) begin
                n_fail++;
                $display("FAIL lap_resume cyc %0d: got %b want %b", i, obs(), exp_vec());
            end
        end
        n_chk++;
        if (state !== 2'd3) begin
            n_fail++;
            $display("FAIL lap_resume_state: state %0d want 3", state);
        end
    endtask

    task automatic test_pause_phase();
        bit seen;
        int r_at, gap;
        do_reset();
        for (int i = 0; i < 14; i++) begin
            cyc(i < 6 ? 1'b0 : 1'b1, 1'b1);
        end
        seen = 0;
        for (int i = 0; i < 30 && !seen; i++) begin
            cyc(1'b1, 1'b1);
            n_chk++;
            if (obs() !== exp_vec()) begin
                n_fail++;
                $display("FAIL phase_wait: got %b want %b", obs(), exp_vec());
            end
            if (count_enable === 1'b1) seen = 1;
        end
        n_chk++;
        if (!seen) begin
            n_fail++;
            $display("FAIL phase_tick_timeout: got no tick want tick");
        end
        for (int i = 0; i < 58; i++) begin
            if (i < 7) cyc(1'b1, 1'b1);
            else       cyc((i < 13) ? 1'b0 : 1'b1, 1'b1);
            n_chk++;
            if (obs() !== exp_vec()) begin
                n_fail++;
                $display("FAIL phase_pause cyc %0d: got %b want %b", i, obs(), exp_vec());
            end
        end
        n_chk++;
        if (state !== 2'd2) begin
            n_fail++;
            $display("FAIL phase_paused: state %0d want 2", state);
        end
        r_at = -1;
        gap  = -1;
        for (int i = 1; i <= 30; i++) begin
            cyc(i <= 6 ? 1'b0 : 1'b1, 1'b1);
            n_chk++;
            if (obs() !== exp_vec()) begin
                n_fail++;
                $display("FAIL phase_resume cyc %0d: got %b want %b", i, obs(), exp_vec());
            end
            if (state === 2'd1 && r_at < 0) r_at = i;
            if (count_enable === 1'b1 && r_at >= 0 && gap < 0) gap = i - r_at;
        end
        n_chk++;
        if (gap !== 6) begin
            n_fail++;
            $display("FAIL phase_gap: got %0d want 6", gap);
        end
    endtask

    task automatic test_clear();
        int nclr;
        for (int i = 0; i < 14; i++) begin
            cyc(i < 6 ? 1'b0 : 1'b1, 1'b1);
            n_chk++;
            if (obs() !== exp_vec()) begin
                n_fail++;
                $display("FAIL clear_pause cyc %0d: got %b want %b", i, obs(), exp_vec());
            end
        end
        nclr = 0;
        for (int i = 1; i <= 14; i++) begin
            cyc(1'b1, i <= 6 ? 1'b0 : 1'b1);
            n_chk++;
            if (obs() !== exp_vec()) begin
                n_fail++;
                $display("FAIL clear_seq cyc %0d: got %b want %b", i, obs(), exp_vec());
            end
            if (cnt_clear === 1'b1) begin
                nclr++;
                n_chk++;
                if (state !== 2'd0 || display_hold !== 1'b0 || dut.r_pre !== 4'(TD - 1)) begin
                    n_fail++;
                    $display("FAIL clear_state: state %0d hold %b pre %0d want 0 0 %0d",
                             state, display_hold, dut.r_pre, TD - 1);
                end
            end
        end
        n_chk++;
        if (nclr !== 1) begin
            n_fail++;
            $display("FAIL clear_width: got %0d want 1", nclr);
        end
        for (int i = 0; i < 14; i++) begin
            cyc(i < 6 ? 1'b0 : 1'b1, i < 6 ? 1'b0 : 1'b1);
            n_chk++;
            if (obs() !== exp_vec()) begin
                n_fail++;
                $display("FAIL both_seq cyc %0d: got %b want %b", i, obs(), exp_vec());
            end
        end
        n_chk++;
        if (state !== 2'd1 || display_hold !== 1'b0) begin
            n_fail++;
            $display("FAIL both_press: state %0d hold %b want 1 0", state, display_hold);
        end
    endtask

    task automatic test_reset_midrun();
        do_reset();
        for (int i = 0; i < 25; i++) begin
            cyc(i < 6 ? 1'b0 : 1'b1, 1'b1);
        end
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        n_chk++;
        if (obs() !== 6'd0) begin
            n_fail++;
            $display("FAIL midrun_reset: got %b want %b", obs(), 6'd0);
        end
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, 1'b1);
            n_chk++;
            if (obs() !== exp_vec()) begin
                n_fail++;
                $display("FAIL midrun_after cyc %0d: got %b want %b", i, obs(), exp_vec());
            end
        end
    endtask

    task automatic test_stop_tick();
        bit seen;
        int extra;
        do_reset();
        for (int i = 0; i < 14; i++) begin
            cyc(i < 6 ? 1'b0 : 1'b1, 1'b1);
        end
        seen = 0;
        for (int i = 0; i < 30 && !seen; i++) begin
            cyc(1'b1, 1'b1);
            if (count_enable === 1'b1) seen = 1;
        end
        n_chk++;
        if (!seen) begin
            n_fail++;
            $display("FAIL stop_tick_timeout: got no tick want tick");
        end
        repeat (3) cyc(1'b1, 1'b1);
        extra = 0;
        for (int i = 1; i <= 44; i++) begin
            cyc(i <= 6 ? 1'b0 : 1'b1, 1'b1);
            n_chk++;
            if (obs() !== exp_vec()) begin
                n_fail++;
                $display("FAIL stop_seq cyc %0d: got %b want %b", i, obs(), exp_vec());
            end
            if (i == 7) begin
                n_chk++;
                if (state !== 2'd2 || count_enable !== 1'b1) begin
                    n_fail++;
                    $display("FAIL stop_last_tick: state %0d ce %b want 2 1", state, count_enable);
                end
            end
            if (i > 7 && count_enable === 1'b1) extra++;
        end
        n_chk++;
        if (extra !== 0) begin
            n_fail++;
            $display("FAIL stop_no_more: got %0d pulses want 0", extra);
        end
    endtask

    task automatic test_random();
        bit ss, lap;
        do_reset();
        ss  = 1'b1;
        lap = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 4) == 0) ss = ~ss;
            if ($urandom_range(0, 4) == 0) lap = ~lap;
            cyc(ss, lap);
            n_chk++;
            if (obs() !== exp_vec()) begin
                n_fail++;
                $display("FAIL random cyc %0d: got %b want %b", i, obs(), exp_vec());
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_start();
        test_bounce();
        test_lap();
        test_pause_phase();
        test_clear();
        test_reset_midrun();
        test_stop_tick();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
